// File: rtl/pc_stack_nb.sv
// pc_stack_nb: D-bit program counter with a DEPTH-entry hardware return-address stack
module pc_stack_nb #(
    parameter int D     = 16,
    parameter int DEPTH = 8,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [D-1:0]   i_in,
    input  logic           i_clr,
    input  logic           i_load,
    input  logic           i_call,
    input  logic           i_ret,
    input  logic           i_inc,
    output logic [D-1:0]   o_out,
    output logic [SPW-1:0] o_sp,
    output logic           o_empty,
    output logic           o_full,
    output logic           o_ovf,
    output logic           o_unf
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [D-1:0]   pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic [D-1:0]   stk_q [DEPTH];
    logic           push;
    logic           full, empty;
    logic [D-1:0]   pc_inc;
    logic [AW-1:0]  wr_idx, rd_idx;

    assign full    = sp_q == SPW'(DEPTH);
    assign empty   = sp_q == '0;
    assign pc_inc  = pc_q + 1'b1;
    assign wr_idx  = AW'(sp_q);
    assign rd_idx  = AW'(sp_q - 1'b1);
    assign o_out   = pc_q;
    assign o_sp    = sp_q;
    assign o_empty = empty;
    assign o_full  = full;
    assign o_ovf   = ovf_q;
    assign o_unf   = unf_q;

    // Pick the single highest-priority command and compute next PC, sp, flags and push
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (i_clr) begin
            pc_d  = '0;
            sp_d  = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (i_load) begin
            pc_d = i_in;
        end else if (i_call) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                push = 1'b1;
                sp_d = sp_q + 1'b1;
                pc_d = i_in;
            end
        end else if (i_ret) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d = sp_q - 1'b1;
                pc_d = stk_q[rd_idx];
            end
        end else if (i_inc) begin
            pc_d = pc_inc;
        end
    end

    // PC, stack pointer and sticky flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; a call writes the return address into the next free slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) stk_q[k] <= '0;
        end else if (push) begin
            stk_q[wr_idx] <= pc_inc;
        end
    end
endmodule

// File: tb/tb_pc_stack_nb.sv
// tb_pc_stack_nb: directed bench with a queue-based reference model of pc_stack_nb
module tb_pc_stack_nb;
    localparam int D = 16;
    localparam int DEPTH = 8;
    localparam int SPW = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [D-1:0]   in = '0;
    logic           clr = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0, inc = 1'b0;
    logic [D-1:0]   out;
    logic [SPW-1:0] sp;
    logic           empty, full, ovf, unf;

    int checks = 0;
    int errors = 0;

    logic [D-1:0] m_pc;
    logic [D-1:0] m_stk[$];
    logic         m_ovf, m_unf;

    pc_stack_nb #(.D(D), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .i_in(in), .i_clr(clr), .i_load(load),
        .i_call(call), .i_ret(ret), .i_inc(inc), .o_out(out), .o_sp(sp),
        .o_empty(empty), .o_full(full), .o_ovf(ovf), .o_unf(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: LIFO queue, one command per edge in priority order
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
        end else if (clr) begin
            m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
        end else if (load) begin
            m_pc = in;
        end else if (call) begin
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else begin m_stk.push_back(m_pc + 16'd1); m_pc = in; end
        end else if (ret) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (inc) begin
            m_pc = m_pc + 16'd1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_out", out, m_pc);
            chk("m_sp", sp, m_stk.size());
            chk("m_empty", empty, m_stk.size() == 0);
            chk("m_full", full, m_stk.size() == DEPTH);
            chk("m_ovf", ovf, m_ovf);
            chk("m_unf", unf, m_unf);
        end
    end

    task automatic cmd(input logic c, input logic l, input logic k, input logic r,
                       input logic n, input logic [D-1:0] v);
        clr = c; load = l; call = k; ret = r; inc = n; in = v;
        @(posedge clk); #1;
        clr = 0; load = 0; call = 0; ret = 0; inc = 0; in = '0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        #1;
        chk("rst_out", out, 0); chk("rst_sp", sp, 0); chk("rst_empty", empty, 1);
        chk("rst_full", full, 0); chk("rst_ovf", ovf, 0); chk("rst_unf", unf, 0);
        // 1: count to 3 then asynchronous reset between edges
        repeat (3) cmd(0, 0, 0, 0, 1, 0);
        chk("count3", out, 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_out", out, 0); chk("async_empty", empty, 1);
        #1 rst_n = 1'b1;
        // 2: wrap
        cmd(0, 1, 0, 0, 0, 16'hFFFE); chk("load_fffe", out, 16'hFFFE);
        cmd(0, 0, 0, 0, 1, 0);        chk("inc_ffff", out, 16'hFFFF);
        cmd(0, 0, 0, 0, 1, 0);        chk("inc_wrap", out, 16'h0000);
        // 3: priority
        cmd(0, 1, 0, 0, 0, 16'h0005);
        cmd(1, 1, 0, 0, 1, 16'h1234); chk("clr_wins", out, 0);
        cmd(0, 1, 1, 0, 1, 16'h1234); chk("load_wins", out, 16'h1234); chk("load_wins_sp", sp, 0);
        // hold
        cmd(0, 0, 0, 0, 0, 16'hBEEF); chk("hold", out, 16'h1234);
        // 4: call/ret
        cmd(0, 1, 0, 0, 0, 16'h0010);
        cmd(0, 0, 1, 1, 1, 16'h0100); chk("call_pc", out, 16'h0100); chk("call_sp", sp, 1);
        cmd(0, 0, 0, 1, 1, 16'h7777); chk("ret_pc", out, 16'h0011); chk("ret_sp", sp, 0);
        chk("ret_empty", empty, 1);
        // 5: fill, overflow, drain, underflow
        cmd(0, 1, 0, 0, 0, 16'h0A00);
        for (int i = 0; i < 8; i++) cmd(0, 0, 1, 0, 0, 16'h2000 + 16'(i) * 16'h0100);
        chk("fill_pc", out, 16'h2700); chk("fill_full", full, 1); chk("fill_ovf", ovf, 0);
        cmd(0, 0, 1, 0, 0, 16'h2800);
        chk("ovf_pc", out, 16'h2700); chk("ovf_sp", sp, 8); chk("ovf_full", full, 1); chk("ovf_flag", ovf, 1);
        for (int k = 0; k < 8; k++) begin
            cmd(0, 0, 0, 1, 0, 0);
            chk("lifo", out, k < 7 ? 32'h2601 - 32'(k) * 32'h100 : 32'h0A01);
        end
        chk("drain_empty", empty, 1);
        cmd(0, 0, 0, 1, 0, 0);
        chk("unf_pc", out, 16'h0A01); chk("unf_flag", unf, 1); chk("unf_ovf_sticky", ovf, 1);
        cmd(0, 0, 0, 0, 1, 0); chk("unf_sticky", unf, 1);
        cmd(1, 0, 0, 0, 0, 0);
        chk("clr_ovf", ovf, 0); chk("clr_unf", unf, 0); chk("clr_pc", out, 0);
        // 6: return address wraps
        cmd(0, 1, 0, 0, 0, 16'hFFFF);
        cmd(0, 0, 1, 0, 0, 16'h0200); chk("wrapcall_pc", out, 16'h0200); chk("wrapcall_sp", sp, 1);
        cmd(0, 0, 0, 1, 0, 0);        chk("wrapret_pc", out, 16'h0000);
        // reset with a non-empty stack
        cmd(0, 0, 1, 0, 0, 16'h0300);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_sp", sp, 0); chk("rst_mid_out", out, 0);
        #1 rst_n = 1'b1;
        cmd(0, 0, 0, 1, 0, 0); chk("rst_mid_unf", unf, 1);
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
